rdyack_merge: RTL and testbench

Registered N-to-1 rdy/ack merge controller: arbitrates round-robin among N requesting rdy/ack sources and forwards the winner into a single full-throughput output register stage. It is the fan-in counterpart of the N-way broadcast controller and sits where several producers share one consumer, such as result write-back or a shared memory port. The block is control-only: the datapath register lives outside and is driven by the one-hot `o_load` strobe and the `dst_sel` index.

---
 rtl/rdyack_merge.sv | 127 ++++++++++++
 tb/tb_rdyack_merge.sv | 123 ++++++++++++
 2 files changed

// File: rtl/rdyack_merge.sv
// rdyack_merge -- registered N-to-1 rdy/ack merge controller.
//
// Round-robin arbitration among N rdy/ack sources feeding one output register
// stage. This block is control only. The external data register captures
// source i when o_load[i] is high, and dst_sel names the source whose beat is
// currently held.
//
// Parameters: N (sources, >= 2), SW (index width, derived).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   src_rdys/src_acks   per-source request / acknowledge (ack is one-hot or 0)
//   src_lasts           per-source end-of-burst, used only with burst lock
//   dst_rdy/dst_ack     output valid (registered) / output acknowledge
//   dst_sel             index of the held beat's source (registered)
//   o_load              data-register capture strobe, identical to src_acks
//
// Optional feature: define RDYACK_MERGE_LOCK_EN to compile in burst lock. In
// that mode a source that starts a burst keeps the grant until its last beat.
module rdyack_merge #(
  parameter int N  = 2,
  parameter int SW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  src_rdys,
  output logic [N-1:0]  src_acks,
  input  logic [N-1:0]  src_lasts,
  output logic          dst_rdy,
  input  logic          dst_ack,
  output logic [SW-1:0] dst_sel,
  output logic [N-1:0]  o_load
);

  logic [SW-1:0] ptr;
  logic          can_load;
  logic          rr_hit;
  logic [SW-1:0] rr_idx;
  logic          g_hit;
  logic [SW-1:0] g_idx;
  logic          load;

  assign can_load = !dst_rdy || dst_ack;

  // Round-robin search starting one past the last winner, wrapping mod N.
  always_comb begin
    int cand;
    cand   = 0;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int o = 1; o <= N; o++) begin
      cand = (int'(ptr) + o) % N;
      if (!rr_hit && src_rdys[cand]) begin
        rr_hit = 1'b1;
        rr_idx = SW'(cand);
      end
    end
  end

`ifdef RDYACK_MERGE_LOCK_EN
  typedef enum logic {S_IDLE, S_LOCKED} lock_t;
  lock_t         lock_st, lock_st_nxt;
  logic [SW-1:0] lock_idx, lock_idx_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_st  <= S_IDLE;
      lock_idx <= '0;
    end else begin
      lock_st  <= lock_st_nxt;
      lock_idx <= lock_idx_nxt;
    end
  end

  // While locked the grant is pinned to the bursting source. Other sources
  // wait even if the pinned one is momentarily not requesting.
  always_comb begin
    lock_st_nxt  = lock_st;
    lock_idx_nxt = lock_idx;
    g_hit        = rr_hit;
    g_idx        = rr_idx;
    if (lock_st == S_LOCKED) begin
      g_hit = src_rdys[lock_idx];
      g_idx = lock_idx;
    end
    if (load) begin
      if (lock_st == S_IDLE && !src_lasts[g_idx]) begin
        lock_st_nxt  = S_LOCKED;
        lock_idx_nxt = g_idx;
      end else if (lock_st == S_LOCKED && src_lasts[lock_idx]) begin
        // ptr picks up lock_idx through the normal load path.
        lock_st_nxt = S_IDLE;
      end
    end
  end
`else
  logic unused_lasts;
  assign unused_lasts = ^src_lasts;
  assign g_hit = rr_hit;
  assign g_idx = rr_idx;
`endif

  // Acks are gated by reset so that a held request is not consumed in the
  // reset cycle.
  assign load = can_load && g_hit && !i_rst;

  always_comb begin
    src_acks = '0;
    if (load) src_acks[g_idx] = 1'b1;
  end

  assign o_load = src_acks;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dst_rdy <= 1'b0;
      dst_sel <= '0;
      ptr     <= SW'(N - 1);
    end else if (load) begin
      dst_rdy <= 1'b1;
      dst_sel <= g_idx;
      ptr     <= g_idx;
    end else if (dst_ack) begin
      dst_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rdyack_merge.sv
// Directed bench for rdyack_merge with N=4. Inputs are driven 1 time unit
// after the rising edge. Outputs are checked 1 time unit after that, well
// before the next rising edge.
module tb_rdyack_merge;
  localparam int N  = 4;
  localparam int SW = 2;

  logic          i_clk;
  logic          i_rst;
  logic [N-1:0]  src_rdys;
  logic [N-1:0]  src_acks;
  logic [N-1:0]  src_lasts;
  logic          dst_rdy;
  logic          dst_ack;
  logic [SW-1:0] dst_sel;
  logic [N-1:0]  o_load;

  int checks = 0;
  int errors = 0;

  rdyack_merge #(.N(N)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .src_rdys(src_rdys), .src_acks(src_acks), .src_lasts(src_lasts),
    .dst_rdy(dst_rdy), .dst_ack(dst_ack), .dst_sel(dst_sel), .o_load(o_load)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge i_clk);
    #1;
  endtask

  // Drive inputs, settle, then check comb acks and registered outputs.
  task automatic step(input logic [N-1:0] rdys, input logic ack, input logic [N-1:0] lasts,
                      input string tag, input logic [N-1:0] e_acks, input logic e_rdy,
                      input logic [SW-1:0] e_sel);
    src_rdys  = rdys;
    dst_ack   = ack;
    src_lasts = lasts;
    #1;
    chk({tag, ".acks"}, 32'(src_acks), 32'(e_acks));
    chk({tag, ".rdy"},  32'(dst_rdy),  32'(e_rdy));
    chk({tag, ".sel"},  32'(dst_sel),  32'(e_sel));
    nxt();
  endtask

  initial begin
    i_rst = 1'b1; src_rdys = '0; dst_ack = 1'b0; src_lasts = '1;
    nxt();
    // Reset holds off acks even with everyone requesting.
    src_rdys = 4'b1111; dst_ack = 1'b1;
    #1;
    chk("rst.acks", 32'(src_acks), 32'h0);
    chk("rst.load", 32'(o_load), 32'h0);
    nxt();
    chk("rst.rdy", 32'(dst_rdy), 32'h0);
    chk("rst.sel", 32'(dst_sel), 32'h0);
    i_rst = 1'b0;

    // Full request with dst_ack held high: rotation 0,1,2,3,0.
    step(4'b1111, 1'b1, 4'b1111, "rr0", 4'b0001, 1'b0, 2'd0);
    step(4'b1111, 1'b1, 4'b1111, "rr1", 4'b0010, 1'b1, 2'd0);
    step(4'b1111, 1'b1, 4'b1111, "rr2", 4'b0100, 1'b1, 2'd1);
    step(4'b1111, 1'b1, 4'b1111, "rr3", 4'b1000, 1'b1, 2'd2);
    step(4'b1111, 1'b1, 4'b1111, "rr4", 4'b0001, 1'b1, 2'd3);

    // Drain, then backpressure on a single source 2.
    step(4'b0000, 1'b1, 4'b1111, "drn",  4'b0000, 1'b1, 2'd0);
    step(4'b0100, 1'b0, 4'b1111, "bp0",  4'b0100, 1'b0, 2'd0);
    step(4'b0100, 1'b0, 4'b1111, "bp1",  4'b0000, 1'b1, 2'd2);
    step(4'b0100, 1'b0, 4'b1111, "bp2",  4'b0000, 1'b1, 2'd2);
    src_rdys = 4'b0100; dst_ack = 1'b1; #1;
    chk("bp3.load", 32'(o_load), 32'h4);
    step(4'b0100, 1'b1, 4'b1111, "bp3",  4'b0100, 1'b1, 2'd2);

    // Move ptr to 1, then sparse 1001: 3 wins, then 0.
    step(4'b0010, 1'b1, 4'b1111, "sp0",  4'b0010, 1'b1, 2'd2);
    step(4'b1001, 1'b1, 4'b1111, "sp1",  4'b1000, 1'b1, 2'd1);
    step(4'b1001, 1'b1, 4'b1111, "sp2",  4'b0001, 1'b1, 2'd3);

    // Single beat from source 1, then idle drain.
    step(4'b0010, 1'b1, 4'b1111, "id0",  4'b0010, 1'b1, 2'd0);
    step(4'b0000, 1'b0, 4'b1111, "id1",  4'b0000, 1'b1, 2'd1);
    step(4'b0000, 1'b1, 4'b1111, "id2",  4'b0000, 1'b1, 2'd1);
    step(4'b0000, 1'b0, 4'b1111, "id3",  4'b0000, 1'b0, 2'd1);

    // Reset while a beat is held.
    step(4'b0100, 1'b1, 4'b1111, "mr0",  4'b0100, 1'b0, 2'd1);
    i_rst = 1'b1;
    step(4'b1111, 1'b1, 4'b1111, "mr1",  4'b0000, 1'b1, 2'd2);
    i_rst = 1'b0;
    step(4'b1111, 1'b1, 4'b1111, "mr2",  4'b0001, 1'b0, 2'd0);

    // Burst from source 0 (lasts[0] = 0,0,1), everyone requesting.
    i_rst = 1'b1;
    step(4'b0000, 1'b0, 4'b1111, "br_r", 4'b0000, 1'b1, 2'd0);
    i_rst = 1'b0;
`ifdef RDYACK_MERGE_LOCK_EN
    step(4'b1111, 1'b1, 4'b1110, "br0",  4'b0001, 1'b0, 2'd0);
    step(4'b1111, 1'b1, 4'b1110, "br1",  4'b0001, 1'b1, 2'd0);
    step(4'b1111, 1'b1, 4'b1111, "br2",  4'b0001, 1'b1, 2'd0);
    step(4'b1111, 1'b1, 4'b1111, "br3",  4'b0010, 1'b1, 2'd0);
`else
    step(4'b1111, 1'b1, 4'b1110, "br0",  4'b0001, 1'b0, 2'd0);
    step(4'b1111, 1'b1, 4'b1110, "br1",  4'b0010, 1'b1, 2'd0);
    step(4'b1111, 1'b1, 4'b1111, "br2",  4'b0100, 1'b1, 2'd1);
    step(4'b1111, 1'b1, 4'b1111, "br3",  4'b1000, 1'b1, 2'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
